// File: rtl/data_pipe_interconnect_s2m_fifo_if.sv
// Valid/ready/data stream bundle shared by the upstream slave port and the
// downstream master ports.
interface data_inf #(
    parameter int DSIZE = 8
) ();
    logic             valid;
    logic             ready;
    logic [DSIZE-1:0] data;

    modport master (output valid, output data, input ready);
    modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_pipe_interconnect_s2m_fifo.sv
// One-to-NUM stream router behind a DEPTH-entry elastic FIFO, with per-beat
// unicast/broadcast selection and silent discard of out-of-range addresses.
module data_pipe_interconnect_s2m_fifo #(
    parameter int DSIZE = 8,
    parameter int NUM   = 8,
    parameter int NSIZE = (NUM > 1) ? $clog2(NUM) : 1,
    parameter int DEPTH = 4,
    parameter int CSIZE = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [NSIZE-1:0] addr,
    input  logic             bcast,
    data_inf.slaver          s00,
    data_inf.master          m00 [NUM-1:0],
    output logic [CSIZE-1:0] count,
    output logic             drop_err
);
    localparam int               PSIZE   = CSIZE - 1;
    localparam logic [NSIZE:0]   ADDR_LIM = (NSIZE + 1)'(NUM);
    localparam logic [CSIZE-1:0] FULL_CNT = CSIZE'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNI,
        S_BC
    } state_t;

    logic [DSIZE-1:0] r_mem_data [DEPTH];
    logic [NSIZE-1:0] r_mem_addr [DEPTH];
    logic             r_mem_bc   [DEPTH];

    logic [PSIZE-1:0] r_wr_ptr;
    logic [PSIZE-1:0] r_rd_ptr;
    logic [CSIZE-1:0] r_count;
    logic [NUM-1:0]   r_done;
    logic             r_drop;
    state_t           r_state;

    logic             w_ready;
    logic             w_push;
    logic             w_illegal;
    logic             w_write;
    logic             w_pop;
    logic [NSIZE-1:0] w_head_addr;
    logic [DSIZE-1:0] w_head_data;
    logic [NUM-1:0]   w_uni_sel;
    logic [NUM-1:0]   w_m_ready;
    logic [NUM-1:0]   w_m_valid;
    logic [NUM-1:0]   w_hs;
    logic [NUM-1:0]   w_done_nxt;
    logic [PSIZE-1:0] w_rd_nxt;
    logic [CSIZE-1:0] w_cnt_nxt;
    logic             w_head_bc_nxt;
    state_t           w_state_nxt;

    // No pass-through when full: ready depends only on the registered count.
    assign w_ready   = !rst & clk_en & (r_count != FULL_CNT);
    assign w_push    = s00.valid & w_ready;
    assign w_illegal = !bcast & ({1'b0, addr} >= ADDR_LIM);
    assign w_write   = w_push & !w_illegal;

    assign s00.ready = w_ready;
    assign count     = r_count;
    assign drop_err  = r_drop;

    assign w_head_addr = r_mem_addr[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    always_comb begin
        w_uni_sel = '0;
        for (int k = 0; k < NUM; k++) begin
            w_uni_sel[k] = (w_head_addr == NSIZE'(k));
        end
    end

    for (genvar k = 0; k < NUM; k++) begin : g_port
        assign w_m_ready[k]  = m00[k].ready;
        assign m00[k].valid  = w_m_valid[k];
        assign m00[k].data   = w_head_data;
    end

    always_comb begin
        w_m_valid     = '0;
        w_hs          = '0;
        w_pop         = 1'b0;
        w_done_nxt    = r_done;
        w_rd_nxt      = r_rd_ptr;
        w_cnt_nxt     = r_count;
        w_head_bc_nxt = 1'b0;
        w_state_nxt   = r_state;

        if (clk_en) begin
            unique case (r_state)
                S_UNI: begin
                    w_m_valid = w_uni_sel;
                    w_pop     = |(w_uni_sel & w_m_ready);
                end
                S_BC: begin
                    w_m_valid  = ~r_done;
                    w_hs       = ~r_done & w_m_ready;
                    w_pop      = &(r_done | w_hs);
                    w_done_nxt = w_pop ? '0 : (r_done | w_hs);
                end
                default: ;
            endcase
        end

        w_rd_nxt  = r_rd_ptr + PSIZE'(w_pop);
        w_cnt_nxt = r_count + CSIZE'(w_write) - CSIZE'(w_pop);

        // The next head is the beat being written only when the FIFO drains to it.
        w_head_bc_nxt = (w_write && (w_rd_nxt == r_wr_ptr)) ? bcast : r_mem_bc[w_rd_nxt];

        if (w_cnt_nxt == '0) begin
            w_state_nxt = S_IDLE;
        end else if (w_head_bc_nxt) begin
            w_state_nxt = S_BC;
        end else begin
            w_state_nxt = S_UNI;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_done   <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= r_wr_ptr + PSIZE'(w_write);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_drop   <= w_push & w_illegal;
        end
    end

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem_data[r_wr_ptr] <= s00.data;
            r_mem_addr[r_wr_ptr] <= addr;
            r_mem_bc[r_wr_ptr]   <= bcast;
        end
    end
endmodule

// File: doc/data_pipe_interconnect_s2m_fifo.md
# data_pipe_interconnect_S2M_fifo

Parametrised successor to the single-slave/multi-master pipe interconnect. It routes a `data_inf` stream from one upstream slave port to one of `NUM` downstream master ports, selected per beat. A `DEPTH`-entry elastic FIFO replaces the two-register connector/buffer, so upstream throughput is decoupled from downstream stalls and no overflow state exists. Beats may also be broadcast to every master port, or dropped when they carry an illegal address. The block sits between a stream source and a set of per-channel consumers.

## Interface
- `DSIZE`, 8, data width of `s00`/`m00`.
- `NUM`, 8, number of master ports; 2..32.
- `NSIZE`, derived ($clog2(NUM), min 1), width of `addr`.
- `DEPTH`, 4, FIFO entries; power of two, >= 2.
- `CSIZE`, derived ($clog2(DEPTH)+1), width of `count`.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_en`  in  1  global enable; no handshake completes while low.
- `addr`  in  NSIZE  destination port index, sampled with `s00.valid`.
- `bcast`  in  1  broadcast the beat to all ports, sampled with `s00.valid`; overrides `addr`.
- `s00`  data_inf.slaver  DSIZE  upstream stream (valid/ready/data).
- `m00[NUM-1:0]`  data_inf.master  DSIZE  downstream streams.
- `count`  out  CSIZE  current FIFO occupancy.
- `drop_err`  out  1  one-cycle pulse when an illegal-address beat is discarded.

## Operation
- Push: `s00.valid & s00.ready & clk_en`. The push writes {data, addr, bcast} at the write pointer.
- Illegal beat: `!bcast && addr >= NUM`. It is accepted but not written. The next cycle `drop_err` = 1 and `count` is unchanged.
- `s00.ready = !rst & clk_en & (count != DEPTH)`. This is combinational. There is no pass-through when full, even if a pop happens in the same cycle.
- Head entry is valid when `count != 0`.
- Unicast head:
  - `m00[k].valid = clk_en & head_vld & (head_addr == k)`.
  - All other ports have `valid = 0`.
  - Pop on `m00[head_addr].ready & clk_en`.
- Broadcast head:
  - A `done[NUM-1:0]` mask tracks ports that have already taken the beat.
  - `m00[k].valid = clk_en & head_vld & !done[k]`.
  - Each accepting port sets its `done` bit.
  - Pop in the cycle where every `k` is either already done or handshaking now. On pop, `done` clears to 0.
- All `m00[k].data` are driven from the head data register.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Pointers are `CSIZE-1` bits and wrap modulo DEPTH. `count` is CSIZE bits, range 0..DEPTH.
- Ordering is strict FIFO. A stalled head blocks later beats for all ports (no reordering).
- Per-cycle state machine on the head entry:
  - IDLE (count==0) -> UNI or BC when an entry arrives.
  - UNI -> next head or IDLE on pop.
  - BC -> stays in BC while `done` is partial; -> next head or IDLE on full completion.

## Timing
- Reset values: `count` = 0, pointers = 0, `done` = 0, `drop_err` = 0, all `m00[k].valid` = 0, `s00.ready` = 0 while `rst` is high.
- `s00.ready` rises combinationally once `rst` falls, given `clk_en` is high.
- Latency: a beat pushed at edge N is valid on its `m00` port in cycle N+1.
- Throughput is 1 beat/cycle when the downstream is always ready.
- `count` updates the cycle after a push or pop.
- `clk_en` low: all valid/ready outputs are 0 and all state holds.
- `rst` asserted mid-transfer: FIFO contents are discarded and a partial broadcast is aborted. Outputs return to reset values immediately (asynchronously).

## Test plan
- Unicast stream: push data 0x10..0x17 with addr 0..7 and all ready held high. Each beat appears on `m00[addr]` exactly one cycle after its push; `count` never exceeds 1.
- Backpressure, DEPTH=4: `m00[2].ready` = 0, push 6 beats to addr 2. The first 4 are accepted, then `s00.ready` = 0 and `count` = 4. After releasing ready, all beats drain in order and `count` returns to 0.
- Broadcast with NUM=4: push 0xAA with `bcast` = 1; port readies rise in cycles 1, 3, 3, 5. Each port sees exactly one handshake. The pop happens in cycle 5, after which the next beat 0xBB (addr 1) is presented.
- Illegal address with NUM=5: push addr 6 data 0x55. `drop_err` pulses once, `count` stays 0, and no `m00[k].valid` is asserted.
- clk_en gating: deassert `clk_en` for 3 cycles with a beat pending. Valids and `s00.ready` go to 0 and `count` holds. After re-enable, delivery resumes with the same data.
- Async reset mid-broadcast: assert `rst` between edges with `done` = 0b0011. All valids drop immediately. After release, `count` = 0 and `done` = 0, and a new beat routes normally.
